// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and build timestamp, compares them,
// retries with a gap on mismatch or stall timeout, and publishes pass/fail.
//
// state | meaning
// IDLE  | waiting for start (or the automatic first check after reset)
// RD_ID | read of address 0 in progress
// RD_TS | read of address 1 in progress
// CMP   | compare captured words against the expected values
// GAP   | idle spacing before the next attempt
// PASS  | check finished, both words matched
// FAIL  | check finished, all attempts used
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1520443765,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned RETRY_GAP      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    sysid_boot_checker_if.master        avm,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        ok_o,
    output logic                        fail_o,
    output logic [1:0]                  err_code_o,
    output logic [31:0]                 id_value_o,
    output logic [31:0]                 ts_value_o,
    output logic [2:0]                  attempts_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CMP   = 3'd3,
        GAP   = 3'd4,
        PASS  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(RETRY_GAP - 1);
    localparam logic [2:0] MAX_ATT  = 3'(MAX_RETRIES + 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ID   = 2'd1;
    localparam logic [1:0] ERR_TS   = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    state_t      state_q;
    logic [7:0]  tmo_q;
    logic [7:0]  gap_q;
    logic        auto_q;
    logic        addr_q;
    logic        read_q;
    logic        busy_q;
    logic        done_q;
    logic        ok_q;
    logic        fail_q;
    logic [1:0]  err_q;
    logic [31:0] id_q;
    logic [31:0] ts_q;
    logic [2:0]  att_q;

    logic        start_go_d;
    logic        more_tries_d;
    logic        tmo_hit_d;
    logic [1:0]  cmp_err_d;
    logic        attempt_fail_d;
    logic [1:0]  fail_code_d;

    always_comb begin
        start_go_d   = start_i || auto_q;
        more_tries_d = (att_q < MAX_ATT);
        tmo_hit_d    = ((state_q == RD_ID) || (state_q == RD_TS)) &&
                       avm.avm_waitrequest && (tmo_q == 8'd0);
        cmp_err_d    = ERR_NONE;
        if (id_q != EXPECTED_ID) begin
            cmp_err_d = ERR_ID;
        end else if (CHECK_TS && (ts_q != EXPECTED_TS)) begin
            cmp_err_d = ERR_TS;
        end
        attempt_fail_d = tmo_hit_d || ((state_q == CMP) && (cmp_err_d != ERR_NONE));
        fail_code_d    = (state_q == CMP) ? cmp_err_d : ERR_TMO;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tmo_q   <= 8'd0;
            gap_q   <= 8'd0;
            auto_q  <= AUTO_START;
            addr_q  <= 1'b0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= ERR_NONE;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            att_q   <= 3'd0;
        end else begin
            auto_q <= 1'b0;
            case (state_q)
                IDLE, PASS, FAIL: begin
                    if (start_go_d) begin
                        state_q <= RD_ID;
                        addr_q  <= 1'b0;
                        read_q  <= 1'b1;
                        tmo_q   <= TMO_LOAD;
                        att_q   <= 3'd1;
                        err_q   <= ERR_NONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ok_q    <= 1'b0;
                        fail_q  <= 1'b0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!avm.avm_waitrequest) begin
                        if (state_q == RD_ID) begin
                            id_q <= avm.avm_readdata;
                            if (CHECK_TS) begin
                                state_q <= RD_TS;
                                addr_q  <= 1'b1;
                                tmo_q   <= TMO_LOAD;
                            end else begin
                                state_q <= CMP;
                                read_q  <= 1'b0;
                            end
                        end else begin
                            ts_q    <= avm.avm_readdata;
                            state_q <= CMP;
                            read_q  <= 1'b0;
                        end
                    end else if (tmo_q != 8'd0) begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                CMP: begin
                    if (cmp_err_d == ERR_NONE) begin
                        state_q <= PASS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ok_q    <= 1'b1;
                        err_q   <= ERR_NONE;
                    end
                end
                GAP: begin
                    if (gap_q == 8'd0) begin
                        state_q <= RD_ID;
                        addr_q  <= 1'b0;
                        read_q  <= 1'b1;
                        tmo_q   <= TMO_LOAD;
                        att_q   <= att_q + 3'd1;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                end
            endcase

            // A failed attempt (timeout or compare) overrides the per-state update above.
            if (attempt_fail_d) begin
                read_q <= 1'b0;
                err_q  <= fail_code_d;
                if (more_tries_d) begin
                    state_q <= GAP;
                    gap_q   <= GAP_LOAD;
                end else begin
                    state_q <= FAIL;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    fail_q  <= 1'b1;
                end
            end
        end
    end

    assign avm.avm_address = addr_q;
    assign avm.avm_read    = read_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign ok_o            = ok_q;
    assign fail_o          = fail_q;
    assign err_code_o      = err_q;
    assign id_value_o      = id_q;
    assign ts_value_o      = ts_q;
    assign attempts_o      = att_q;

endmodule
